// File: rtl/resultinstrgen_udiv_28ns_16ns_seq.sv
// ---------------------------------------------------------------------------
// resultinstrgen_udiv_28ns_16ns_seq
//
// Iterative unsigned restoring divider. It recovers a tile index (quotient)
// and an intra-tile offset (remainder) from a linear tile offset (dividend)
// and a stride (divisor). One quotient bit is produced per clock. There is no
// overlap between operations.
//
// Ports:
//   ap_clk           in   clock, rising edge
//   ap_rst_n         in   asynchronous active-low reset
//   in_valid         in   operands valid
//   in_ready         out  divider idle and able to accept operands
//   in_dividend      in   DIVIDEND_WIDTH unsigned dividend
//   in_divisor       in   DIVISOR_WIDTH unsigned divisor
//   out_valid        out  result valid (held until out_ready)
//   out_ready        in   consumer accepts result
//   out_quotient     out  DIVIDEND_WIDTH unsigned quotient
//   out_remainder    out  DIVISOR_WIDTH unsigned remainder
//   out_div_by_zero  out  divisor was zero (quotient all ones, remainder 0)
// ---------------------------------------------------------------------------
module resultinstrgen_udiv_28ns_16ns_seq #(
  parameter int DIVIDEND_WIDTH = 28,
  parameter int DIVISOR_WIDTH  = 16
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] in_dividend,
  input  logic [DIVISOR_WIDTH-1:0]  in_divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIVIDEND_WIDTH-1:0] out_quotient,
  output logic [DIVISOR_WIDTH-1:0]  out_remainder,
  output logic                      out_div_by_zero
);

  localparam int DW    = DIVIDEND_WIDTH;
  localparam int SW    = DIVISOR_WIDTH;
  localparam int CNT_W = $clog2(DIVIDEND_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q,   state_d;
  logic [DW-1:0]     shreg_q,   shreg_d;    // dividend shifts out of the MSB, quotient bits shift into the LSB
  logic [SW-1:0]     divisor_q, divisor_d;
  logic [SW:0]       prem_q,    prem_d;     // partial remainder
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [DW-1:0]     quot_q,    quot_d;
  logic [SW-1:0]     rem_q,     rem_d;
  logic              dz_q,      dz_d;

  // One restoring step. p is {partial_rem, dividend MSB}; its true top bit is
  // prem_q[SW], which can only be set when p already exceeds any divisor, so
  // it forces the subtract and the SW+1-bit difference stays exact.
  logic [SW:0]       p_s;
  logic [SW:0]       diff_s;
  logic              ge_s;
  logic [SW:0]       step_prem_s;
  logic [DW-1:0]     step_shreg_s;

  // Datapath for a single quotient bit.
  always_comb begin
    p_s          = {prem_q[SW-1:0], shreg_q[DW-1]};
    diff_s       = p_s - {1'b0, divisor_q};
    ge_s         = prem_q[SW] | (p_s >= {1'b0, divisor_q});
    step_prem_s  = ge_s ? diff_s : p_s;
    step_shreg_s = {shreg_q[DW-2:0], ge_s};
  end

  // Next-state and datapath load/update selection.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    divisor_d = divisor_q;
    prem_d    = prem_q;
    cnt_d     = cnt_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dz_d      = dz_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (in_divisor == {SW{1'b0}}) begin
            // Divide by zero bypasses the iteration entirely.
            quot_d  = {DW{1'b1}};
            rem_d   = {SW{1'b0}};
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            shreg_d   = in_dividend;
            divisor_d = in_divisor;
            prem_d    = {(SW+1){1'b0}};
            cnt_d     = CNT_W'(DIVIDEND_WIDTH);
            state_d   = S_BUSY;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        shreg_d = step_shreg_s;
        prem_d  = step_prem_s;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Last bit: capture the final result so it is stable in DONE.
          quot_d  = step_shreg_s;
          rem_d   = step_prem_s[SW-1:0];
          dz_d    = 1'b0;
          state_d = S_DONE;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= S_IDLE;
      shreg_q   <= {DW{1'b0}};
      divisor_q <= {SW{1'b0}};
      prem_q    <= {(SW+1){1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      quot_q    <= {DW{1'b0}};
      rem_q     <= {SW{1'b0}};
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      divisor_q <= divisor_d;
      prem_q    <= prem_d;
      cnt_q     <= cnt_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dz_q      <= dz_d;
    end
  end

  assign in_ready        = (state_q == S_IDLE);
  assign out_valid       = (state_q == S_DONE);
  assign out_quotient    = quot_q;
  assign out_remainder   = rem_q;
  assign out_div_by_zero = dz_q;

endmodule

// File: tb/tb_resultinstrgen_udiv_28ns_16ns_seq.sv
module tb_resultinstrgen_udiv_28ns_16ns_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [27:0] in_dividend;
  logic [15:0] in_divisor;
  logic        out_valid;
  logic        out_ready;
  logic [27:0] out_quotient;
  logic [15:0] out_remainder;
  logic        out_div_by_zero;

  int n_vec  = 0;
  int n_miss = 0;

  resultinstrgen_udiv_28ns_16ns_seq dut (
    .ap_clk          (ap_clk),
    .ap_rst_n        (ap_rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_dividend     (in_dividend),
    .in_divisor      (in_divisor),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_quotient    (out_quotient),
    .out_remainder   (out_remainder),
    .out_div_by_zero (out_div_by_zero)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample just after the edge; handshakes never overlap.
  task automatic tick();
    @(posedge ap_clk);
    #1;
    chk("ready_valid_exclusive", {31'd0, in_ready & out_valid}, 32'd0);
  endtask

  // Issue one division, check latency and result against plain arithmetic.
  task automatic run_div(input logic [27:0] a, input logic [15:0] b, input int hold,
                         output logic [27:0] got_q, output logic [15:0] got_r);
    logic [27:0] exp_q;
    logic [15:0] exp_r;
    logic        exp_dz;
    int          exp_lat;
    int          waitc;
    int          lat;
    if (b == 16'd0) begin
      exp_q = 28'hFFFFFFF; exp_r = 16'd0; exp_dz = 1'b1; exp_lat = 0;
    end else begin
      exp_q = a / 28'(b); exp_r = 16'(a % 28'(b)); exp_dz = 1'b0; exp_lat = 28;
    end
    waitc = 0;
    while (!in_ready && waitc < 100) begin
      tick();
      waitc++;
    end
    chk("ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid    = 1'b1;
    in_dividend = a;
    in_divisor  = b;
    tick();
    // Operands after the accepting edge must not matter.
    in_valid    = 1'b0;
    in_dividend = 28'($urandom);
    in_divisor  = 16'($urandom);
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("quotient", {4'd0, out_quotient}, {4'd0, exp_q});
    chk("remainder", {16'd0, out_remainder}, {16'd0, exp_r});
    chk("div_by_zero", {31'd0, out_div_by_zero}, {31'd0, exp_dz});
    got_q = out_quotient;
    got_r = out_remainder;
    if (hold > 0) begin
      out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        in_valid    = 1'b1;
        in_dividend = 28'($urandom);
        in_divisor  = 16'($urandom_range(1, 65535));
        tick();
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_quotient", {4'd0, out_quotient}, {4'd0, exp_q});
        chk("bp_remainder", {16'd0, out_remainder}, {16'd0, exp_r});
        chk("bp_div_by_zero", {31'd0, out_div_by_zero}, {31'd0, exp_dz});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    tick();
    chk("idle_after_handshake", {31'd0, in_ready}, 32'd1);
    chk("valid_dropped", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [27:0] q;
    logic [15:0] r;
    logic [27:0] ra;
    logic [15:0] rb;
    logic [15:0] rr;

    ap_rst_n    = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    in_dividend = 28'd0;
    in_divisor  = 16'd0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_quotient", {4'd0, out_quotient}, 32'd0);
    chk("rst_remainder", {16'd0, out_remainder}, 32'd0);
    chk("rst_div_by_zero", {31'd0, out_div_by_zero}, 32'd0);
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // Directed cases.
    run_div(28'd1000, 16'd7, 0, q, r);
    chk("dir_1000_7_q", {4'd0, q}, 32'd142);
    chk("dir_1000_7_r", {16'd0, r}, 32'd6);
    run_div(28'hFFFFFFF, 16'hFFFF, 0, q, r);
    chk("dir_max_q", {4'd0, q}, 32'h1000);
    chk("dir_max_r", {16'd0, r}, 32'hFFF);
    run_div(28'd5, 16'd9, 0, q, r);
    chk("dir_5_9_q", {4'd0, q}, 32'd0);
    run_div(28'd0, 16'd1, 0, q, r);
    chk("dir_0_1_r", {16'd0, r}, 32'd0);
    run_div(28'd12345, 16'd0, 0, q, r);
    chk("dir_div0_q", {4'd0, q}, 32'hFFFFFFF);
    run_div(28'd1000, 16'd7, 10, q, r);
    run_div(28'd77, 16'd10, 0, q, r);
    chk("after_bp_q", {4'd0, q}, 32'd7);

    // Reset in the middle of an operation.
    in_valid    = 1'b1;
    in_dividend = 28'd40000;
    in_divisor  = 16'd3;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    ap_rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    run_div(28'd40000, 16'd3, 0, q, r);
    chk("post_rst_q", {4'd0, q}, 32'd13333);
    chk("post_rst_r", {16'd0, r}, 32'd1);

    // Random: dividend built as a*b+r so the answer is known by construction.
    for (int k = 0; k < 1000; k++) begin
      ra = 28'($urandom_range(0, 4095));
      rb = 16'($urandom_range(1, 65535));
      rr = 16'($urandom_range(0, 32'(rb) - 1));
      run_div(ra * 28'(rb) + 28'(rr), rb, (k % 50 == 0) ? 3 : 0, q, r);
      chk("rand_q", {4'd0, q}, {4'd0, ra});
      chk("rand_r", {16'd0, r}, {16'd0, rr});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
